stream_bram_writer: RTL and testbench

- Write-side counterpart of the memory control unit, which reads BRAM into AXI-Stream; this block goes from AXI-Stream into BRAM.
- Accepts one AXI-Stream result channel from the data processor and writes each beat sequentially into a BRAM port through a BRAM-controller-style interface.
- A small control FSM sequences a run of data_size words from operation_start to completion and raises interrupt-style busy/complete/error flags.
- One instance per output channel; every instance runs on the FSM clock.

---
 rtl/stream_bram_writer_pkg.sv | 21 ++
 rtl/stream_bram_writer.sv | 180 ++++++++++++++++++
 tb/tb_stream_bram_writer.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_bram_writer_pkg.sv
// ---------------------------------------------------------------------------
// stream_bram_writer_pkg
// Shared types and constants for the AXI-Stream to BRAM writer.
//   state_t      : control FSM states (IDLE, RUN, DONE, ERR)
//   ERR_*        : values reported on error_code
// ---------------------------------------------------------------------------
package stream_bram_writer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_TIMEOUT     = 2'd0;
  localparam logic [1:0] ERR_ZERO_SIZE   = 2'd1;
  localparam logic [1:0] ERR_NO_TLAST    = 2'd2;
  localparam logic [1:0] ERR_EARLY_TLAST = 2'd3;

endpackage

// File: rtl/stream_bram_writer.sv
// ---------------------------------------------------------------------------
// stream_bram_writer
// Accepts one AXI-Stream channel and writes each beat to consecutive BRAM
// addresses, sequenced by a small control FSM.
//
// Optional feature: define STREAM_BRAM_WRITER_TIMEOUT_EN to enable a RUN-state
// watchdog that ends the run with error_code=ERR_TIMEOUT after TIMEOUT_CYCLES
// consecutive cycles without a handshake.
//
// Ports:
//   fsm_clk, rst_n         : clock, asynchronous active-low reset
//   operation_start        : single-cycle start request (honoured in IDLE only)
//   base_addr, data_size   : run parameters, sampled on an accepted start
//   operation_busy         : high in RUN, DONE and ERR
//   operation_complete     : one-cycle pulse on a successful run
//   operation_error        : one-cycle pulse on a failed run
//   error_code             : cause of the last error, held until next start
//   s_axis_*               : stream input (tready depends on state only)
//   bram_*                 : registered BRAM write port, 1 cycle after handshake
//
// Handshake: a beat transfers in a cycle where s_axis_tvalid and s_axis_tready
// are both high at the rising edge; tvalid never influences tready.
// ---------------------------------------------------------------------------
module stream_bram_writer
  import stream_bram_writer_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 32,
  parameter int BYTE_ADDR      = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    fsm_clk,
  input  logic                    rst_n,
  input  logic                    operation_start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [ADDR_WIDTH:0]     data_size,
  output logic                    operation_busy,
  output logic                    operation_complete,
  output logic                    operation_error,
  output logic [1:0]              error_code,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic                    bram_en,
  output logic [DATA_WIDTH/8-1:0] bram_we,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic [DATA_WIDTH-1:0]   bram_wrdata
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] STEP =
    (BYTE_ADDR != 0) ? ADDR_WIDTH'(BYTES) : ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]   size_q, size_d;
  // addr_q always holds base_addr + cnt_q*STEP, kept incrementally so no
  // multiplier is needed; wrap-around is natural ADDR_WIDTH arithmetic.
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            code_q, code_d;
  logic                  handshake;
  logic                  last_beat;
  logic                  timeout;

  assign s_axis_tready      = (state_q == RUN);
  assign handshake          = s_axis_tvalid && s_axis_tready;
  assign last_beat          = (cnt_q == (size_q - CNT_ONE));
  assign operation_busy     = (state_q != IDLE);
  assign operation_complete = (state_q == DONE);
  assign operation_error    = (state_q == ERR);
  assign error_code         = code_q;

`ifdef STREAM_BRAM_WRITER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;

  // Counts consecutive RUN cycles without a handshake.
  always_ff @(posedge fsm_clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else if ((state_q != RUN) || handshake) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WD_W'(1);
    end
  end

  // Fires on the idle cycle that brings the count to TIMEOUT_CYCLES.
  assign timeout = (state_q == RUN) && !handshake &&
                   (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // State and run-context registers.
  always_ff @(posedge fsm_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      size_q  <= '0;
      addr_q  <= '0;
      code_q  <= ERR_TIMEOUT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      code_q  <= code_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    addr_d  = addr_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (operation_start) begin
          if (data_size == '0) begin
            code_d  = ERR_ZERO_SIZE;
            state_d = ERR;
          end else begin
            size_d  = data_size;
            addr_d  = base_addr;
            cnt_d   = '0;
            code_d  = ERR_TIMEOUT;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (handshake) begin
          cnt_d  = cnt_q + CNT_ONE;
          addr_d = addr_q + STEP;
          if (last_beat) begin
            if (s_axis_tlast) begin
              state_d = DONE;
            end else begin
              code_d  = ERR_NO_TLAST;
              state_d = ERR;
            end
          end else if (s_axis_tlast) begin
            code_d  = ERR_EARLY_TLAST;
            state_d = ERR;
          end
        end else if (timeout) begin
          code_d  = ERR_TIMEOUT;
          state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // BRAM write register: every handshake becomes exactly one write in the
  // following cycle; the async reset discards a write that is in flight.
  always_ff @(posedge fsm_clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_en     <= 1'b0;
      bram_we     <= '0;
      bram_addr   <= '0;
      bram_wrdata <= '0;
    end else begin
      bram_en <= handshake;
      bram_we <= handshake ? {BYTES{1'b1}} : '0;
      if (handshake) begin
        bram_addr   <= addr_q;
        bram_wrdata <= s_axis_tdata;
      end
    end
  end

endmodule

// File: tb/tb_stream_bram_writer.sv
// ---------------------------------------------------------------------------
// tb_stream_bram_writer
// Directed bench for stream_bram_writer (DATA_WIDTH=16, ADDR_WIDTH=32,
// byte addressing, TIMEOUT_CYCLES=8 when STREAM_BRAM_WRITER_TIMEOUT_EN).
// A run-level model predicts every output each cycle; directed sections add
// literal checks of the observed write log and pulse counts.
// ---------------------------------------------------------------------------
module tb_stream_bram_writer;

  localparam int DW   = 16;
  localparam int AW   = 32;
  localparam int STEP = 2;
  localparam int TO   = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          operation_start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   data_size = '0;
  logic          operation_busy, operation_complete, operation_error;
  logic [1:0]    error_code;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic          bram_en;
  logic [1:0]    bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wrdata;

  stream_bram_writer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_ADDR(1), .TIMEOUT_CYCLES(TO)
  ) dut (
    .fsm_clk(clk), .rst_n(rst_n),
    .operation_start(operation_start), .base_addr(base_addr),
    .data_size(data_size), .operation_busy(operation_busy),
    .operation_complete(operation_complete), .operation_error(operation_error),
    .error_code(error_code), .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_wrdata(bram_wrdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- run-level model ----------------
  // A run is "active" from accepted start until its final beat; each accepted
  // beat k of a run produces a write to base + k*STEP in the next cycle.
  logic          m_run, m_complete, m_error, m_wr;
  logic [AW:0]   m_cnt, m_size;
  logic [AW-1:0] m_base, m_wr_addr;
  logic [DW-1:0] m_wr_data;
  logic [1:0]    m_code;
  int            m_idle;

  always @(posedge clk or negedge rst_n) begin
    logic hs, pc, pe;
    if (!rst_n) begin
      m_run = 0; m_complete = 0; m_error = 0; m_wr = 0;
      m_cnt = 0; m_size = 0; m_base = 0; m_wr_addr = 0; m_wr_data = 0;
      m_code = 0; m_idle = 0;
    end else begin
      hs = m_run && s_axis_tvalid;
      pc = 0; pe = 0;
      m_wr = hs;
      if (hs) begin
        m_wr_addr = AW'(m_base + AW'(m_cnt) * AW'(STEP));
        m_wr_data = s_axis_tdata;
      end
      if (m_run) begin
        if (hs) begin
          m_idle = 0;
          if (m_cnt + 1 == m_size) begin
            m_run = 0;
            if (s_axis_tlast) pc = 1;
            else begin pe = 1; m_code = 2; end
          end else if (s_axis_tlast) begin
            m_run = 0; pe = 1; m_code = 3;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end else begin
          m_idle++;
`ifdef STREAM_BRAM_WRITER_TIMEOUT_EN
          if (m_idle == TO) begin m_run = 0; pe = 1; m_code = 0; end
`endif
        end
      end else if (!m_complete && !m_error && operation_start) begin
        if (data_size == 0) begin
          pe = 1; m_code = 1;
        end else begin
          m_run = 1; m_cnt = 0; m_size = data_size; m_base = base_addr;
          m_code = 0; m_idle = 0;
        end
      end
      m_complete = pc;
      m_error    = pe;
    end
  end

  // ---------------- compare process + observation log ----------------
  logic [AW-1:0] wr_addr_log[$];
  logic [DW-1:0] wr_data_log[$];
  int n_complete = 0, n_error = 0, n_busy = 0;

  always @(negedge clk) begin
    chk("tready", s_axis_tready, m_run);
    chk("busy", operation_busy, m_run | m_complete | m_error);
    chk("complete", operation_complete, m_complete);
    chk("error", operation_error, m_error);
    chk("error_code", error_code, m_code);
    chk("bram_en", bram_en, m_wr);
    chk("bram_we", bram_we, m_wr ? 2'b11 : 2'b00);
    if (m_wr) begin
      chk("bram_addr", bram_addr, m_wr_addr);
      chk("bram_wrdata", bram_wrdata, m_wr_data);
    end
    if (bram_en) begin
      wr_addr_log.push_back(bram_addr);
      wr_data_log.push_back(bram_wrdata);
    end
    if (operation_complete) n_complete++;
    if (operation_error) n_error++;
    if (operation_busy) n_busy++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr_log.delete();
    wr_data_log.delete();
    n_complete = 0; n_error = 0; n_busy = 0;
  endtask

  task automatic start_run(input logic [AW-1:0] base, input logic [AW:0] size);
    operation_start = 1; base_addr = base; data_size = size;
    step();
    operation_start = 0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last);
    int waited = 0;
    s_axis_tdata = d; s_axis_tlast = last; s_axis_tvalid = 1;
    while (!s_axis_tready && waited < 50) begin step(); waited++; end
    chk("tready_wait_expired", s_axis_tready, 1'b1);
    step();
    s_axis_tvalid = 0; s_axis_tlast = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Compare the write log with exp_q (addresses) and exp_d (data).
  logic [AW-1:0] exp_q[$];
  logic [DW-1:0] exp_d[$];

  task automatic check_log(input string name);
    chk({name, "_nwrites"}, wr_addr_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_addr_log.size(); i++) begin
      chk({name, "_addr"}, wr_addr_log[i], exp_q[i]);
      chk({name, "_data"}, wr_data_log[i], exp_d[i]);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle(3);
    chk("reset_busy", operation_busy, 1'b0);
    chk("reset_tready", s_axis_tready, 1'b0);
    chk("reset_en", bram_en, 1'b0);
    chk("reset_we", bram_we, 2'b00);
    chk("reset_code", error_code, 2'd0);
    chk("reset_addr", bram_addr, 32'h0);
    rst_n = 1;
    idle(2);

    // Basic run
    clear_log();
    start_run(32'h100, 4);
    for (int i = 0; i < 4; i++) send(16'hA0 + 16'(i), i == 3);
    idle(3);
    exp_q = '{32'h100, 32'h102, 32'h104, 32'h106};
    exp_d = '{16'hA0, 16'hA1, 16'hA2, 16'hA3};
    check_log("basic");
    chk("basic_complete", n_complete, 1);
    chk("basic_error", n_error, 0);
    chk("basic_busy_cycles", n_busy, 5);

    // Backpressure gaps
    clear_log();
    start_run(32'h200, 4);
    for (int i = 0; i < 4; i++) begin send(16'hB0 + 16'(i), i == 3); idle(2); end
    idle(2);
    exp_q = '{32'h200, 32'h202, 32'h204, 32'h206};
    exp_d = '{16'hB0, 16'hB1, 16'hB2, 16'hB3};
    check_log("gaps");
    chk("gaps_complete", n_complete, 1);

    // Early tlast
    clear_log();
    start_run(32'h300, 4);
    send(16'hC0, 0);
    send(16'hC1, 1);
    idle(3);
    exp_q = '{32'h300, 32'h302};
    exp_d = '{16'hC0, 16'hC1};
    check_log("early");
    chk("early_code", error_code, 2'd3);
    chk("early_error", n_error, 1);
    chk("early_complete", n_complete, 0);
    chk("early_tready_after", s_axis_tready, 1'b0);

    // Missing tlast
    clear_log();
    start_run(32'h40, 3);
    for (int i = 0; i < 3; i++) send(16'hD0 + 16'(i), 0);
    idle(3);
    exp_q = '{32'h40, 32'h42, 32'h44};
    exp_d = '{16'hD0, 16'hD1, 16'hD2};
    check_log("notlast");
    chk("notlast_code", error_code, 2'd2);
    chk("notlast_error", n_error, 1);

    // Zero size
    clear_log();
    start_run(32'h50, 0);
    idle(3);
    chk("zero_nwrites", wr_addr_log.size(), 0);
    chk("zero_code", error_code, 2'd1);
    chk("zero_error", n_error, 1);
    chk("zero_busy_cycles", n_busy, 1);

    // Reset mid-run: the second write is in flight and must be discarded
    clear_log();
    start_run(32'h600, 5);
    send(16'hE0, 0);
    send(16'hE1, 0);
    #2 rst_n = 0;
    #1;
    chk("midrst_en", bram_en, 1'b0);
    chk("midrst_we", bram_we, 2'b00);
    chk("midrst_busy", operation_busy, 1'b0);
    chk("midrst_tready", s_axis_tready, 1'b0);
    chk("midrst_addr", bram_addr, 32'h0);
    idle(2);
    rst_n = 1;
    idle(1);
    chk("midrst_nwrites", wr_addr_log.size(), 1);
    chk("midrst_pulses", n_complete + n_error, 0);

    // Restart from a new base; a start during RUN must be ignored
    clear_log();
    start_run(32'h400, 2);
    send(16'hF0, 0);
    start_run(32'h800, 1);
    send(16'hF1, 1);
    idle(3);
    exp_q = '{32'h400, 32'h402};
    exp_d = '{16'hF0, 16'hF1};
    check_log("restart");
    chk("restart_complete", n_complete, 1);
    chk("restart_error", n_error, 0);

    // Address wrap-around at the top of the space
    clear_log();
    start_run(32'hFFFF_FFFE, 2);
    send(16'h1234, 0);
    send(16'h5678, 1);
    idle(2);
    exp_q = '{32'hFFFF_FFFE, 32'h0000_0000};
    exp_d = '{16'h1234, 16'h5678};
    check_log("wrap");
    chk("wrap_complete", n_complete, 1);

    // Stalled stream
    clear_log();
    start_run(32'h700, 4);
    send(16'h77, 0);
    idle(100);
`ifdef STREAM_BRAM_WRITER_TIMEOUT_EN
    chk("timeout_error", n_error, 1);
    chk("timeout_code", error_code, 2'd0);
    chk("timeout_nwrites", wr_addr_log.size(), 1);
    chk("timeout_busy", operation_busy, 1'b0);
`else
    chk("stall_error", n_error, 0);
    chk("stall_busy", operation_busy, 1'b1);
    for (int i = 1; i < 4; i++) send(16'h77 + 16'(i), i == 3);
    idle(2);
    chk("stall_complete", n_complete, 1);
    chk("stall_nwrites", wr_addr_log.size(), 4);
`endif

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
